// File: rtl/ex_operand_stage_pkg.sv
// rtl/ex_operand_stage_pkg.sv - op codes and ALU control codes shared by the operand stage and the ALU
package ex_operand_stage_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_ADDI = 3'd4,
        OP_ANDI = 3'd5,
        OP_ORI  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Register-register ops are the only ones whose rs2 field is a real source.
    function automatic logic is_reg_reg(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// rtl/ex_operand_stage_fwd_mux.sv - per-operand bypass select: MEM over WB over register-file data
module fwd_mux #(
    parameter int DWIDTH = 32,
    parameter int RWIDTH = 5
) (
    input  logic [RWIDTH-1:0] idx,
    input  logic [DWIDTH-1:0] reg_data,
    input  logic              mem_wen,
    input  logic              mem_is_load,
    input  logic [RWIDTH-1:0] mem_rd,
    input  logic [DWIDTH-1:0] mem_data,
    input  logic              wb_wen,
    input  logic [RWIDTH-1:0] wb_rd,
    input  logic [DWIDTH-1:0] wb_data,
    output logic [DWIDTH-1:0] data
);

    // A MEM-stage load has no data yet; the hazard logic stalls instead.
    always_comb begin
        data = reg_data;
        if (idx == '0) begin
            data = '0;
        end else if (mem_wen && !mem_is_load && (mem_rd == idx)) begin
            data = mem_data;
        end else if (wb_wen && (wb_rd == idx)) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - one-slot operand stage: bypass, load-use stall and ALU operand steering
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int DWIDTH            = 32,
    parameter int ALU_CONTROL_WIDTH = 4,
    parameter int RWIDTH            = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_id_valid,
    output logic                         o_id_ready,
    input  logic [2:0]                   i_id_op,
    input  logic [DWIDTH-1:0]            i_id_rs1_data,
    input  logic [DWIDTH-1:0]            i_id_rs2_data,
    input  logic [DWIDTH-1:0]            i_id_imm,
    input  logic [RWIDTH-1:0]            i_id_rs1,
    input  logic [RWIDTH-1:0]            i_id_rs2,
    input  logic [RWIDTH-1:0]            i_id_rd,
    input  logic                         i_mem_wen,
    input  logic                         i_mem_is_load,
    input  logic [RWIDTH-1:0]            i_mem_rd,
    input  logic [DWIDTH-1:0]            i_mem_data,
    input  logic                         i_wb_wen,
    input  logic [RWIDTH-1:0]            i_wb_rd,
    input  logic [DWIDTH-1:0]            i_wb_data,
    input  logic                         i_flush,
    output logic                         o_ex_valid,
    input  logic                         i_ex_ready,
    output logic [DWIDTH-1:0]            o_alu_in1,
    output logic [DWIDTH-1:0]            o_alu_in2,
    output logic [ALU_CONTROL_WIDTH-1:0] o_alu_ctrl,
    output logic [RWIDTH-1:0]            o_ex_rd
);

    logic              valid_q;
    op_e               op_q;
    logic [DWIDTH-1:0] rs1_data_q;
    logic [DWIDTH-1:0] rs2_data_q;
    logic [DWIDTH-1:0] imm_q;
    logic [RWIDTH-1:0] rs1_q;
    logic [RWIDTH-1:0] rs2_q;
    logic [RWIDTH-1:0] rd_q;

    logic              hazard;
    logic              id_accept;
    logic              drain;
    logic [DWIDTH-1:0] fwd_rs1;
    logic [DWIDTH-1:0] fwd_rs2;
    logic [3:0]        ctrl_raw;

    assign hazard = valid_q && i_mem_wen && i_mem_is_load && (i_mem_rd != '0) &&
                    ((i_mem_rd == rs1_q) || (is_reg_reg(op_q) && (i_mem_rd == rs2_q)));

    assign o_ex_valid = valid_q && !hazard && !i_flush;
    assign drain      = o_ex_valid && i_ex_ready;
    assign o_id_ready = !valid_q || drain;
    assign id_accept  = i_id_valid && o_id_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q    <= 1'b0;
            op_q       <= OP_ADD;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else begin
            if (id_accept) begin
                op_q       <= op_e'(i_id_op);
                rs1_data_q <= i_id_rs1_data;
                rs2_data_q <= i_id_rs2_data;
                imm_q      <= i_id_imm;
                rs1_q      <= i_id_rs1;
                rs2_q      <= i_id_rs2;
                rd_q       <= i_id_rd;
            end
            // Flush wins over a same-cycle load; the reserved op is swallowed.
            if (i_flush) begin
                valid_q <= 1'b0;
            end else if (id_accept) begin
                valid_q <= (op_e'(i_id_op) != OP_RSVD);
            end else if (drain) begin
                valid_q <= 1'b0;
            end
        end
    end

    fwd_mux #(.DWIDTH(DWIDTH), .RWIDTH(RWIDTH)) u_fwd_rs1 (
        .idx         (rs1_q),
        .reg_data    (rs1_data_q),
        .mem_wen     (i_mem_wen),
        .mem_is_load (i_mem_is_load),
        .mem_rd      (i_mem_rd),
        .mem_data    (i_mem_data),
        .wb_wen      (i_wb_wen),
        .wb_rd       (i_wb_rd),
        .wb_data     (i_wb_data),
        .data        (fwd_rs1)
    );

    fwd_mux #(.DWIDTH(DWIDTH), .RWIDTH(RWIDTH)) u_fwd_rs2 (
        .idx         (rs2_q),
        .reg_data    (rs2_data_q),
        .mem_wen     (i_mem_wen),
        .mem_is_load (i_mem_is_load),
        .mem_rd      (i_mem_rd),
        .mem_data    (i_mem_data),
        .wb_wen      (i_wb_wen),
        .wb_rd       (i_wb_rd),
        .wb_data     (i_wb_data),
        .data        (fwd_rs2)
    );

    // SUB swaps operands because the ALU computes in2 - in1.
    always_comb begin
        ctrl_raw  = ALU_AND;
        o_alu_in1 = fwd_rs1;
        o_alu_in2 = fwd_rs2;
        case (op_q)
            OP_ADD:  ctrl_raw = ALU_ADD;
            OP_SUB: begin
                ctrl_raw  = ALU_SUB;
                o_alu_in1 = fwd_rs2;
                o_alu_in2 = fwd_rs1;
            end
            OP_AND:  ctrl_raw = ALU_AND;
            OP_OR:   ctrl_raw = ALU_OR;
            OP_ADDI: begin
                ctrl_raw  = ALU_ADD;
                o_alu_in2 = imm_q;
            end
            OP_ANDI: begin
                ctrl_raw  = ALU_AND;
                o_alu_in2 = imm_q;
            end
            OP_ORI: begin
                ctrl_raw  = ALU_OR;
                o_alu_in2 = imm_q;
            end
            default: ctrl_raw = ALU_AND;
        endcase
    end

    assign o_alu_ctrl = valid_q ? ALU_CONTROL_WIDTH'(ctrl_raw) : '0;
    assign o_ex_rd    = rd_q;

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: datapath width.
REQ-002 SHALL have parameter ALU_CONTROL_WIDTH, default 4: ALU control width.
REQ-003 SHALL have parameter RWIDTH, default 5: register-index width.
REQ-004 SHALL have port i_clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port i_rstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports i_id_valid (input, 1) and o_id_ready (output, 1): decode-side handshake.
REQ-007 SHALL have port i_id_op, input, 3: op code (ADD=0, SUB=1, AND=2, OR=3, ADDI=4, ANDI=5, ORI=6, 7 reserved).
REQ-008 SHALL have ports i_id_rs1_data, i_id_rs2_data, i_id_imm, inputs, DWIDTH each: register-file operands and immediate.
REQ-009 SHALL have ports i_id_rs1, i_id_rs2, i_id_rd, inputs, RWIDTH each: source and destination indices.
REQ-010 SHALL have ports i_mem_wen (1), i_mem_is_load (1), i_mem_rd (RWIDTH) and i_mem_data (DWIDTH), all inputs: MEM-stage forwarding source.
REQ-011 SHALL have ports i_wb_wen (1), i_wb_rd (RWIDTH) and i_wb_data (DWIDTH), all inputs: WB-stage forwarding source.
REQ-012 SHALL have port i_flush, input, 1: kill the held instruction.
REQ-013 SHALL have ports o_ex_valid (output, 1) and i_ex_ready (input, 1): execute-side handshake.
REQ-014 SHALL have ports o_alu_in1 and o_alu_in2, outputs, DWIDTH each, and o_alu_ctrl, output, ALU_CONTROL_WIDTH: ALU operands and control.
REQ-015 SHALL have port o_ex_rd, output, RWIDTH: destination index of the held instruction.

Function
REQ-016 SHALL hold one instruction slot (valid_q plus the registered fields of REQ-007..009).
REQ-017 SHALL assert hazard when valid_q, i_mem_wen, i_mem_is_load and i_mem_rd!=0 all hold and i_mem_rd matches rs1_q, or matches rs2_q for a register-register op.
REQ-018 SHALL drive o_ex_valid = valid_q & ~hazard & ~i_flush, combinationally.
REQ-019 SHALL drive o_id_ready = ~valid_q | (o_ex_valid & i_ex_ready).
REQ-020 SHALL load the slot on i_id_valid & o_id_ready; op 7 SHALL be accepted and dropped (valid_q=0).
REQ-021 SHALL clear valid_q on drain without a simultaneous load.
REQ-022 SHALL give i_flush priority: valid_q=0 next edge, overriding any same-cycle load.
REQ-023 SHALL forward per operand with priority MEM (i_mem_wen, non-load, rd match) > WB (i_wb_wen, rd match) > registered data; index 0 SHALL never forward and SHALL read 0.
REQ-024 SHALL re-evaluate forwarding every cycle against the registered indices.
REQ-025 SHALL encode o_alu_ctrl as AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110.
REQ-026 SHALL, because the ALU computes in2 + ~in1 + 1, drive SUB as in1=fwd_rs2, in2=fwd_rs1.
REQ-027 SHALL drive ADD/AND/OR with in1=fwd_rs1, in2=fwd_rs2.
REQ-028 SHALL drive ADDI/ANDI/ORI with in1=fwd_rs1, in2=imm_q.
REQ-029 SHALL have latency of one cycle from accept to o_ex_valid when no hazard is present.
REQ-030 SHALL add exactly one bubble cycle per load-use hazard.
REQ-031 SHALL keep registered fields unchanged while o_ex_valid & ~i_ex_ready.

Reset
REQ-032 SHALL, on i_rstn low, set valid_q=0 and clear all registered fields, immediately and asynchronously.
REQ-033 SHALL hold o_ex_valid=0, o_id_ready=1, o_alu_ctrl=4'b0000 and o_ex_rd=0 during reset.
REQ-034 SHALL discard an in-flight instruction on reset mid-operation, with no partial output after release.

Structure
REQ-035 SHALL take op codes and ALU control codes from the shared definitions header, which the ALU also includes.
REQ-036 SHALL implement forwarding in one sub-module, fwd_mux, instantiated once per source operand.

Verification
REQ-037 Accept ADD rs1=1 (5), rs2=2 (3) -> next cycle o_ex_valid=1, ctrl=0010, in1=5, in2=3.
REQ-038 Accept SUB rs1=10, rs2=4 -> in1=4, in2=10, ctrl=0110; ALU result 6.
REQ-039 MEM non-load rd=1 data=7 and WB rd=1 data=9, instruction reads rs1=1 -> in1=7; with rd=0 instead -> in1=0.
REQ-040 MEM load rd=2, held ADD uses rs2=2 -> o_ex_valid=0 for one cycle; then WB data forwarded, o_ex_valid=1.
REQ-041 i_ex_ready=0 for 3 cycles -> o_id_ready=0 and outputs stable; ready=1 with new i_id_valid -> drain and reload same edge.
REQ-042 i_flush with i_id_valid -> valid_q=0 next edge; op 7 accepted -> o_ex_valid stays 0; i_rstn low mid-stall -> o_ex_valid=0 at once.
